fetch_debug_ctrl: RTL and testbench
===================================

Name: fetch_debug_ctrl

Overview:
- Sequences the instruction-fetch stage from a byte-serial debug link.
- Decodes command bytes and loads 32-bit instruction words into instruction memory through the fetch stage's write port.
- Then runs the pipeline continuously or single-steps it, and stops on a halt report from the pipeline.
- Sits between the UART receiver and the InstructionFetch/pipeline enable inputs.

Parameters:
ADDR_WIDTH, 10, instruction memory address width; depth = 2**ADDR_WIDTH words
HALT_WORD, 32'hFFFFFFFF, instruction word that terminates a program load
CMD_LOAD, 8'h01, command byte: start program load
CMD_RUN, 8'h02, command byte: continuous run
CMD_STEP, 8'h03, command byte: enter step mode
CMD_TICK, 8'h04, in step mode: advance one clock
CMD_EXIT, 8'h05, in step mode: leave to IDLE

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
i_rx_data  input  8  received byte
i_rx_done  input  1  one-cycle strobe: i_rx_data valid
i_halt  input  1  pipeline reports HALT_WORD retired (level or pulse)
o_write_inst_mem  output  1  instruction memory write strobe
o_inst_mem_addr  output  ADDR_WIDTH  write address
o_inst_mem_data  output  32  write data
o_enable  output  1  pipeline/fetch enable
o_pipe_clear  output  1  one-cycle pulse clearing pipeline state before execution
o_program_loaded  output  1  a complete program is resident
o_load_error  output  1  last load overflowed memory without HALT_WORD
o_done  output  1  execution finished (halt seen)
o_cycle_count  output  32  clocks executed since last o_pipe_clear

Behaviour:
- Interface: one clock (clk). Reset rst is asynchronous and active-high.
- Reset values: all outputs 0; state IDLE; byte index 0; address 0.
- All outputs are registered.
- States: IDLE, LOAD, WRITE, RUN, STEP, DONE.
- IDLE:
  - CMD_LOAD -> LOAD. Clears o_program_loaded, o_load_error, o_done, and the address.
  - CMD_RUN -> RUN, or CMD_STEP -> STEP, only if o_program_loaded=1; otherwise ignored.
  - Any other byte is ignored.
- LOAD:
  - Bytes assemble a word MSB first: byte 0 goes to bits [31:24], and so on.
  - On the 4th byte strobe (cycle N), the next state is WRITE.
- WRITE (exactly one cycle, N+1):
  - o_write_inst_mem=1, with o_inst_mem_addr = current address and o_inst_mem_data = assembled word.
  - If word == HALT_WORD: o_program_loaded=1 in cycle N+2 and the state returns to IDLE.
  - Else if address == 2**ADDR_WIDTH-1: o_load_error=1 and the state returns to IDLE; o_program_loaded stays 0.
  - Else: address increments and the state returns to LOAD.
  - An i_rx_done arriving during WRITE is captured as byte 0 of the next word; no byte is lost.
- Entry to RUN or STEP: o_pipe_clear=1 for the first cycle in the new state; o_cycle_count is cleared in the same cycle.
- RUN:
  - o_enable=1 every cycle after the clear cycle.
  - i_halt=1 -> DONE in the next cycle; o_enable drops the same cycle DONE is entered.
  - Rx bytes are ignored.
- STEP:
  - o_enable=0 by default.
  - Each CMD_TICK strobe produces o_enable=1 for exactly one cycle, in the following cycle.
  - CMD_EXIT -> IDLE. i_halt=1 -> DONE.
  - If i_halt and a TICK strobe coincide, halt wins and no enable pulse is issued.
- DONE:
  - o_done=1, o_enable=0.
  - CMD_LOAD -> LOAD (reload); CMD_RUN/CMD_STEP re-execute the resident program (clear pulse again).
- o_cycle_count increments on every cycle with o_enable=1 and saturates at 32'hFFFFFFFF.
- Reset asserted mid-load or mid-run: immediate return to reset values. The partially loaded program is treated as invalid (o_program_loaded=0).
- i_rx_done during o_pipe_clear is processed normally per the new state's rules.

Test Plan:
- Load: rst pulse; bytes 01, 00 00 00 0A, 00 00 00 14, FF FF FF FF -> write pulses at addr 0/1/2 with data 0x0A/0x14/0xFFFFFFFF; o_program_loaded=1 after the third write.
- Run: after load, byte 02; i_halt raised 7 cycles after o_pipe_clear -> o_enable high 7 cycles; o_cycle_count=7; o_done=1; o_enable=0.
- Step: byte 03, then three 04 strobes spaced 5 cycles apart -> exactly three single-cycle o_enable pulses; o_cycle_count=3. Then byte 05 -> IDLE, o_done=0.
- Guard and overflow: byte 02 with no program -> no o_pipe_clear and o_enable stays 0. With ADDR_WIDTH=2, load of four non-halt words -> writes at addr 0..3, o_load_error=1, o_program_loaded=0.
- Collision and reset: in STEP, i_halt and a 04 strobe in the same cycle -> no enable pulse, DONE. Assert rst after the 2nd byte of a load word -> all outputs 0; the next 01 load starts at addr 0.

Source files
------------

// File: rtl/fetch_debug_ctrl.sv
// Debug-link sequencer for the fetch stage: decodes command bytes, loads
// instruction words into instruction memory, then runs or single-steps the pipeline.
module fetch_debug_ctrl #(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] HALT_WORD  = 32'hFFFFFFFF,
    parameter logic [7:0]  CMD_LOAD   = 8'h01,
    parameter logic [7:0]  CMD_RUN    = 8'h02,
    parameter logic [7:0]  CMD_STEP   = 8'h03,
    parameter logic [7:0]  CMD_TICK   = 8'h04,
    parameter logic [7:0]  CMD_EXIT   = 8'h05
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_done,
    input  logic                  i_halt,
    output logic                  o_write_inst_mem,
    output logic [ADDR_WIDTH-1:0] o_inst_mem_addr,
    output logic [31:0]           o_inst_mem_data,
    output logic                  o_enable,
    output logic                  o_pipe_clear,
    output logic                  o_program_loaded,
    output logic                  o_load_error,
    output logic                  o_done,
    output logic [31:0]           o_cycle_count
);

    // Byte link handshake: i_rx_data is valid only in the cycle i_rx_done is high;
    // there is no back-pressure, so every strobe is consumed or deliberately ignored.

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_WRITE, S_RUN, S_STEP, S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

    state_t      state;
    logic [1:0]  byte_idx;
    logic [23:0] word_hi;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= S_IDLE;
            byte_idx         <= 2'd0;
            word_hi          <= 24'd0;
            o_write_inst_mem <= 1'b0;
            o_inst_mem_addr  <= '0;
            o_inst_mem_data  <= 32'd0;
            o_enable         <= 1'b0;
            o_pipe_clear     <= 1'b0;
            o_program_loaded <= 1'b0;
            o_load_error     <= 1'b0;
            o_done           <= 1'b0;
            o_cycle_count    <= 32'd0;
        end else begin
            o_write_inst_mem <= 1'b0;
            o_pipe_clear     <= 1'b0;
            if (o_enable && o_cycle_count != 32'hFFFFFFFF)
                o_cycle_count <= o_cycle_count + 32'd1;

            case (state)
                S_IDLE, S_DONE: begin
                    o_enable <= 1'b0;
                    if (i_rx_done) begin
                        if (i_rx_data == CMD_LOAD) begin
                            state            <= S_LOAD;
                            byte_idx         <= 2'd0;
                            o_inst_mem_addr  <= '0;
                            o_program_loaded <= 1'b0;
                            o_load_error     <= 1'b0;
                            o_done           <= 1'b0;
                        end else if (i_rx_data == CMD_RUN && o_program_loaded) begin
                            state         <= S_RUN;
                            o_pipe_clear  <= 1'b1;
                            o_cycle_count <= 32'd0;
                            o_done        <= 1'b0;
                        end else if (i_rx_data == CMD_STEP && o_program_loaded) begin
                            state         <= S_STEP;
                            o_pipe_clear  <= 1'b1;
                            o_cycle_count <= 32'd0;
                            o_done        <= 1'b0;
                        end
                    end
                end
                S_LOAD: begin
                    if (i_rx_done) begin
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: word_hi[23:16] <= i_rx_data;
                            2'd1: word_hi[15:8]  <= i_rx_data;
                            2'd2: word_hi[7:0]   <= i_rx_data;
                            default: begin
                                o_inst_mem_data  <= {word_hi, i_rx_data};
                                o_write_inst_mem <= 1'b1;
                                state            <= S_WRITE;
                            end
                        endcase
                    end
                end
                S_WRITE: begin
                    if (o_inst_mem_data == HALT_WORD) begin
                        o_program_loaded <= 1'b1;
                        state            <= S_IDLE;
                    end else if (o_inst_mem_addr == ADDR_LAST) begin
                        o_load_error <= 1'b1;
                        state        <= S_IDLE;
                    end else begin
                        o_inst_mem_addr <= o_inst_mem_addr + 1'b1;
                        state           <= S_LOAD;
                        // A byte landing in the write cycle starts the next word.
                        if (i_rx_done) begin
                            word_hi[23:16] <= i_rx_data;
                            byte_idx       <= 2'd1;
                        end
                    end
                end
                S_RUN: begin
                    if (i_halt) begin
                        o_enable <= 1'b0;
                        o_done   <= 1'b1;
                        state    <= S_DONE;
                    end else begin
                        o_enable <= 1'b1;
                    end
                end
                S_STEP: begin
                    o_enable <= 1'b0;
                    if (i_halt) begin
                        o_done <= 1'b1;
                        state  <= S_DONE;
                    end else if (i_rx_done && i_rx_data == CMD_TICK) begin
                        o_enable <= 1'b1;
                    end else if (i_rx_done && i_rx_data == CMD_EXIT) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_debug_ctrl.sv
// Bench for fetch_debug_ctrl: memory writes are scoreboarded against an expected
// queue, enable/clear activity is counted by a monitor and checked per scenario.
module tb_fetch_debug_ctrl;

    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    i_rx_data = 8'd0;
    logic          i_rx_done = 1'b0;
    logic          i_halt = 1'b0;
    logic          o_write_inst_mem;
    logic [AW-1:0] o_inst_mem_addr;
    logic [31:0]   o_inst_mem_data;
    logic          o_enable;
    logic          o_pipe_clear;
    logic          o_program_loaded;
    logic          o_load_error;
    logic          o_done;
    logic [31:0]   o_cycle_count;

    fetch_debug_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .i_rx_data(i_rx_data), .i_rx_done(i_rx_done), .i_halt(i_halt),
        .o_write_inst_mem(o_write_inst_mem), .o_inst_mem_addr(o_inst_mem_addr),
        .o_inst_mem_data(o_inst_mem_data), .o_enable(o_enable),
        .o_pipe_clear(o_pipe_clear), .o_program_loaded(o_program_loaded),
        .o_load_error(o_load_error), .o_done(o_done), .o_cycle_count(o_cycle_count)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [AW+31:0] exp_q[$];
    int en_cnt = 0, clr_cnt = 0, en_double = 0;
    logic en_prev = 1'b0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // scoreboard / activity monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (o_write_inst_mem) begin
            if (exp_q.size() == 0) check("unexpected_write", 64'(o_inst_mem_addr), 64'hFFFF);
            else check("mem_write", 64'({o_inst_mem_addr, o_inst_mem_data}), 64'(exp_q.pop_front()));
        end
        if (o_enable) en_cnt++;
        if (o_enable && en_prev) en_double++;
        if (o_pipe_clear) clr_cnt++;
        en_prev = o_enable;
    end

    // driver tasks
    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        i_rx_data = b;
        i_rx_done = 1'b1;
        @(posedge clk); #1;
        i_rx_done = 1'b0;
    endtask

    task automatic send_word(input logic [AW-1:0] addr, input logic [31:0] w);
        exp_q.push_back({addr, w});
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic zero_counts();
        @(negedge clk);
        en_cnt = 0; clr_cnt = 0; en_double = 0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ctrl"}, 64'({o_write_inst_mem, o_inst_mem_addr, o_enable, o_pipe_clear,
                                   o_program_loaded, o_load_error, o_done}), 64'd0);
        check({tag, "_data"}, 64'(o_inst_mem_data), 64'd0);
        check({tag, "_count"}, 64'(o_cycle_count), 64'd0);
    endtask

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;

        // program load: three words, last is the halt word
        send_byte(8'h01);
        send_word(2'd0, 32'h0000000A);
        send_word(2'd1, 32'h00000014);
        send_word(2'd2, 32'hFFFFFFFF);
        @(negedge clk);
        check("loaded_during_write", 64'(o_program_loaded), 64'd0);
        wait_cycles(1);
        check("loaded_after_write", 64'(o_program_loaded), 64'd1);
        check("load_error_clean", 64'(o_load_error), 64'd0);

        // continuous run, halt raised seven cycles after the clear pulse
        zero_counts();
        send_byte(8'h02);
        repeat (7) @(posedge clk);
        #1 i_halt = 1'b1;
        @(posedge clk);
        #1 i_halt = 1'b0;
        @(negedge clk);
        check("run_enable_cycles", 64'(en_cnt), 64'd7);
        check("run_clear_pulses", 64'(clr_cnt), 64'd1);
        check("run_cycle_count", 64'(o_cycle_count), 64'd7);
        check("run_done", 64'(o_done), 64'd1);
        check("run_enable_off", 64'(o_enable), 64'd0);

        // single step: three ticks, then exit
        zero_counts();
        send_byte(8'h03);
        for (int t = 0; t < 3; t++) begin
            repeat (5) @(posedge clk);
            send_byte(8'h04);
        end
        wait_cycles(3);
        check("step_pulses", 64'(en_cnt), 64'd3);
        check("step_single_cycle", 64'(en_double), 64'd0);
        check("step_clear_pulses", 64'(clr_cnt), 64'd1);
        check("step_cycle_count", 64'(o_cycle_count), 64'd3);
        send_byte(8'h05);
        send_byte(8'h04);
        wait_cycles(3);
        check("step_exit_done", 64'(o_done), 64'd0);
        check("idle_tick_ignored", 64'(en_cnt), 64'd3);

        // halt and tick in the same cycle: halt wins
        send_byte(8'h03);
        wait_cycles(2);
        zero_counts();
        @(posedge clk); #1;
        i_rx_data = 8'h04; i_rx_done = 1'b1; i_halt = 1'b1;
        @(posedge clk); #1;
        i_rx_done = 1'b0; i_halt = 1'b0;
        wait_cycles(3);
        check("collision_no_enable", 64'(en_cnt), 64'd0);
        check("collision_done", 64'(o_done), 64'd1);

        // reset after two bytes of a load word
        send_byte(8'h01);
        send_byte(8'h12);
        send_byte(8'h34);
        #1 rst = 1'b1;
        @(negedge clk);
        check_reset_values("midload_reset");
        @(posedge clk); #1 rst = 1'b0;

        // run with no program resident is ignored
        zero_counts();
        send_byte(8'h02);
        wait_cycles(5);
        check("guard_no_clear", 64'(clr_cnt), 64'd0);
        check("guard_no_enable", 64'(en_cnt), 64'd0);

        // fresh load restarts at address 0
        send_byte(8'h01);
        send_word(2'd0, 32'hDEADBEEF);
        send_word(2'd1, 32'hFFFFFFFF);
        wait_cycles(2);
        check("reload_loaded", 64'(o_program_loaded), 64'd1);

        // overflow: four non-halt words fill the 4-word memory
        send_byte(8'h01);
        for (int a = 0; a < 4; a++)
            send_word(AW'(a), 32'($urandom_range(0, 32'hFFFFFFFE)));
        wait_cycles(3);
        check("overflow_error", 64'(o_load_error), 64'd1);
        check("overflow_not_loaded", 64'(o_program_loaded), 64'd0);
        check("writes_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "bench time limit");
    end

endmodule
